instr_fetch_buffer: RTL
=======================

// Module: instr_fetch_buffer
// PURPOSE
//  Fetch stage upstream of the single-cycle decode/execute datapath.
//  - Issues sequential word fetches to instruction memory over a req/rsp handshake.
//  - Buffers returned instructions, each with its PC, in a DEPTH-entry in-order FIFO.
//  - Presents one instruction per cycle to the datapath on a valid/ready interface.
//  - Flushes all state and restarts fetch on a redirect (taken branch, jal/jalr, reset).
// PARAMETERS
//  DEPTH     4             FIFO entries and max outstanding requests; power of 2, >=2
//  RESET_PC  32'h0000_0000 fetch address after reset
// PORTS
//  SYS_clk            in   1   single clock, all state on rising edge
//  SYS_reset_n        in   1   asynchronous active-low reset
//  IMEM_req_valid     out  1   fetch request valid
//  IMEM_req_ready     in   1   memory accepts request
//  IMEM_req_addr      out  32  fetch address, always word aligned
//  IMEM_rsp_valid     in   1   response valid; responses in request order, latency >=1
//  IMEM_rsp_data      in   32  fetched instruction word
//  redirect_valid     in   1   flush and restart fetch at redirect_PC
//  redirect_PC        in   32  new fetch address
//  instruction_valid  out  1   head entry valid
//  instruction        out  32  head instruction word
//  instruction_PC     out  32  PC of head instruction
//  instruction_ready  in   1   datapath consumes head this cycle
//  fetch_fault        out  1   sticky: misaligned redirect seen
// BEHAVIOUR
//  Reset values (async, while SYS_reset_n=0)
//  - fetch_PC=RESET_PC; FIFO empty; outstanding=0; discard=0; fetch_fault=0.
//  - All outputs 0 except IMEM_req_addr=RESET_PC.
//  Issue
//  - IMEM_req_valid=1 when outstanding+occupancy<DEPTH, no redirect this cycle,
//    and fetch_fault=0.
//  - IMEM_req_addr=fetch_PC.
//  - Accept = valid&ready -> fetch_PC+=4 (mod 2^32; wraps 32'hFFFF_FFFC->0) and
//    outstanding+=1.
//  Response
//  - IMEM_rsp_valid decrements outstanding.
//  - discard>0: data dropped, discard-=1.
//  - Otherwise: {data, PC} written to FIFO tail.
//  - Response PC comes from a parallel PC FIFO of issued addresses, or resp_PC
//    tracking; it must match the accepted address order.
//  Dequeue
//  - valid&ready pops the head. Push and pop in the same cycle are legal, including
//    when full.
//  - Occupancy never exceeds DEPTH: issue credit guarantees space, so no overflow check.
//  Redirect (highest priority)
//  - FIFO emptied; instruction_valid=0 next cycle.
//  - Pop in the same cycle is ignored.
//  - discard = outstanding + accept_this_cycle - rsp_this_cycle. IMEM_req_valid is
//    forced 0 in the redirect cycle, so accept_this_cycle=0.
//  - fetch_PC=redirect_PC; issue resumes the next cycle.
//  - Responses still owed to discard are never enqueued.
//  - redirect_PC[1:0]!=0: fetch_fault=1 (sticky until reset); issue stops; FIFO flushed.
//  Latency
//  - Empty FIFO, rsp in cycle N: instruction_valid in cycle N+1.
//  - Redirect in N: earliest request in N+1.
//  - Reset mid-operation clears everything immediately. No pending response survives;
//    the memory side must also be reset.
// CONFIGURATION
//  IFB_BYPASS_EN defined:
//  - FIFO empty, rsp_valid, discard=0, no redirect: rsp data/PC drive instruction*
//    combinationally in the same cycle.
//  - If instruction_ready=1, the entry is not written; otherwise it is enqueued.
//  IFB_BYPASS_EN undefined:
//  - Every response passes through the FIFO (1-cycle minimum).
//  - Outputs come only from FIFO state.
// TESTING
//  1 Reset release, ready=1, mem latency 1: reqs 0x0,0x4,0x8...; instruction_PC
//    sequence 0x0,0x4 with data matching; one instr/cycle steady state.
//  2 instruction_ready=0, DEPTH=4: exactly 4 reqs accepted, then IMEM_req_valid=0;
//    ready=1 -> PCs 0x0..0xC delivered in order, fetch resumes at 0x10.
//  3 3 outstanding (latency 3), redirect_PC=0x100: next 3 rsps dropped;
//    first delivered instruction_PC=0x100.
//  4 Redirect and pop same cycle with 2 entries: FIFO empty next cycle;
//    next req addr=redirect_PC.
//  5 redirect_PC=0x102: fetch_fault=1, no further reqs, instruction_valid=0 until reset.
//  6 fetch_PC=0xFFFF_FFF8: reqs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0. Async reset mid-burst
//    clears outputs without waiting for a clock edge.
//  7 IFB_BYPASS_EN, empty FIFO, rsp in cycle N with ready=1: instruction_valid in N.
//    Undefined: valid in N+1.

Source files
------------

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer
//   Fetch stage ahead of the single-cycle decode/execute datapath. It issues
//   sequential word fetches over a req/rsp handshake and buffers each returned
//   instruction with its PC in a DEPTH-entry in-order FIFO. The head entry is
//   offered to the datapath on a valid/ready interface. A redirect flushes
//   everything and restarts fetch at the new PC.
//   Optional feature macro: IFB_BYPASS_EN
//     defined   - a response arriving at an empty FIFO is presented on
//                 instruction* in the same cycle, and is only written into
//                 the FIFO if the datapath does not take it.
//     undefined - every response passes through the FIFO.
module instr_fetch_buffer #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        SYS_clk,
   input  logic        SYS_reset_n,
   output logic        IMEM_req_valid,
   input  logic        IMEM_req_ready,
   output logic [31:0] IMEM_req_addr,
   input  logic        IMEM_rsp_valid,
   input  logic [31:0] IMEM_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_PC,
   output logic        instruction_valid,
   output logic [31:0] instruction,
   output logic [31:0] instruction_PC,
   input  logic        instruction_ready,
   output logic        fetch_fault
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   logic [31:0]   fetch_pc;
   logic [31:0]   resp_pc;
   logic [31:0]   data_mem [DEPTH];
   logic [31:0]   pc_mem   [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [CW-1:0] count;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] discard;
   logic          fault;

   logic [CW:0]   credit_used;
   logic          head_valid;
   logic          req_fire;
   logic          rsp_drop;
   logic          rsp_keep;
   logic          push;
   logic          pop;

   // Issue credit, response classification and FIFO push/pop decisions
   always_comb begin
      credit_used    = {1'b0, outstanding} + {1'b0, count};
      head_valid     = (count != '0);
      IMEM_req_valid = SYS_reset_n & ~fault & ~redirect_valid &
                       (credit_used < (CW + 1)'(DEPTH));
      IMEM_req_addr  = fetch_pc;
      req_fire       = IMEM_req_valid & IMEM_req_ready;
      rsp_drop       = IMEM_rsp_valid & (discard != '0);
      rsp_keep       = IMEM_rsp_valid & (discard == '0) & ~redirect_valid;
      pop            = head_valid & instruction_ready & ~redirect_valid;
      fetch_fault    = fault;
`ifdef IFB_BYPASS_EN
      // An empty FIFO lets a kept response go straight to the datapath;
      // it is only stored when the datapath is not ready for it.
      push = rsp_keep & ~(~head_valid & instruction_ready);
      if (head_valid) begin
         instruction_valid = 1'b1;
         instruction       = data_mem[head];
         instruction_PC    = pc_mem[head];
      end else if (rsp_keep & SYS_reset_n) begin
         instruction_valid = 1'b1;
         instruction       = IMEM_rsp_data;
         instruction_PC    = resp_pc;
      end else begin
         instruction_valid = 1'b0;
         instruction       = '0;
         instruction_PC    = '0;
      end
`else
      push              = rsp_keep;
      instruction_valid = head_valid;
      instruction       = head_valid ? data_mem[head] : '0;
      instruction_PC    = head_valid ? pc_mem[head]   : '0;
`endif
   end

   // Fetch pointer, response tracking, discard credit, FIFO pointers and fault
   always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
      if (!SYS_reset_n) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
         fault       <= 1'b0;
         head        <= '0;
         tail        <= '0;
         count       <= '0;
      end else begin
         outstanding <= outstanding + CW'(req_fire) - CW'(IMEM_rsp_valid);
         if (redirect_valid) begin
            // Every response still owed, minus the one arriving now (which is
            // dropped here), belongs to the old stream. No request is accepted
            // in this cycle, so nothing new is added.
            fetch_pc <= {redirect_PC[31:2], 2'b00};
            resp_pc  <= {redirect_PC[31:2], 2'b00};
            discard  <= outstanding - CW'(IMEM_rsp_valid);
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            if (redirect_PC[1:0] != 2'b00) begin
               fault <= 1'b1;
            end
         end else begin
            if (req_fire) begin
               fetch_pc <= fetch_pc + 32'd4;
            end
            if (rsp_drop) begin
               discard <= discard - CW'(1);
            end
            // Responses return in request order and accepted addresses are
            // sequential from the last redirect, so a running counter gives
            // the PC of each kept response.
            if (rsp_keep) begin
               resp_pc <= resp_pc + 32'd4;
            end
            if (push) begin
               tail <= tail + AW'(1);
            end
            if (pop) begin
               head <= head + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   // Instruction/PC storage; contents are only observed through valid entries
   always_ff @(posedge SYS_clk) begin
      if (push) begin
         data_mem[tail] <= IMEM_rsp_data;
         pc_mem[tail]   <= resp_pc;
      end
   end

endmodule
